ram_dp_clr: RTL and testbench

//  Parametrised simple-dual-port RAM: one write port, one read port, one clock.
//  - Byte-enabled writes; registered reads with a read-valid strobe.
//  - Write-first bypass when reading and writing the same address.
//  - Hardware clear sweep after reset and on request.

---
 rtl/ram_pkg.sv | 29 ++
 rtl/ram_clear_fsm.sv | 87 ++++++++
 rtl/ram_dp_clr.sv | 151 +++++++++++++++
 tb/tb_ram_dp_clr.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ram_pkg
//   Shared definitions for the clearable simple-dual-port RAM.
//   - BYTE_W  : width of one byte lane covered by a single write enable.
//   - state_t : clear-sweep controller states (idle / sweeping).
//   - clog2   : address width helper, never returns less than 1 so that a
//               single-word RAM still has a usable address port.
package ram_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Ceiling log2 with a floor of 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ram_clear_fsm.sv
// ram_clear_fsm
//   Sequencer for the hardware clear sweep of ram_dp_clr. When started it
//   walks an address counter from 0 to DEPTH-1, one word per cycle, and
//   asks the array to write zero at each address.
// Parameters
//   DEPTH          number of words to sweep
//   CLEAR_ON_RESET non-zero: start a sweep straight out of reset
// Ports
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset; restarts the sweep at 0
//   clr      in   request a sweep; only honoured while busy is low
//   busy     out  high in the cycle after reset and for the whole sweep
//   clr_we   out  write-zero strobe for the array
//   clr_add  out  address to zero this cycle
module ram_clear_fsm
    import ram_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int CLEAR_ON_RESET = 1,
    localparam int ADDR_W        = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_add
);

    localparam logic [ADDR_W-1:0] LAST_ADD = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_next;
    logic              in_reset;

    // State, sweep counter and the one-cycle "just left reset" flag. The flag
    // keeps busy high for the first cycle after reset even when no sweep is
    // configured, so the user ports are never live in that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            cnt      <= '0;
            in_reset <= 1'b1;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            in_reset <= 1'b0;
        end
    end

    // Next state: a sweep ends on the edge that zeroes the last word, and a
    // clr request arriving while busy is simply dropped.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_IDLE: begin
                if (clr && !in_reset) begin
                    state_next = ST_CLEAR;
                    cnt_next   = '0;
                end
            end
            ST_CLEAR: begin
                if (cnt == LAST_ADD) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        busy    = in_reset || (state == ST_CLEAR);
        clr_we  = (state == ST_CLEAR);
        clr_add = cnt;
    end

endmodule

// File: rtl/ram_dp_clr.sv
// ram_dp_clr
//   Parametrised simple-dual-port RAM (one write port, one read port, one
//   clock) with byte-enabled writes, registered reads, write-first bypass on
//   same-address collisions and a hardware clear sweep.
// Parameters
//   DATA_W          word width, multiple of 8
//   DEPTH           number of words, any positive value
//   RD_LAT          read latency, 1 or 2 cycles
//   CLEAR_ON_RESET  non-zero: zero the array after reset
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   clr       in   request a full clear (ignored while busy)
//   busy      out  in reset or clearing; wr, rd, clr ignored while high
//   wr        in   write enable
//   wr_add    in   write address
//   wr_data   in   write data
//   wr_be     in   byte enables, bit i covers wr_data[8i+7:8i]
//   rd        in   read request
//   rd_add    in   read address
//   rd_data   out  read data, holds its value between reads
//   rd_valid  out  one-cycle strobe marking rd_data as fresh
module ram_dp_clr
    import ram_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int DEPTH          = 8,
    parameter int RD_LAT         = 1,
    parameter int CLEAR_ON_RESET = 1,
    localparam int ADDR_W        = clog2(DEPTH),
    localparam int BE_W          = DATA_W / BYTE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              busy,
    input  logic              wr,
    input  logic [ADDR_W-1:0] wr_add,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BE_W-1:0]   wr_be,
    input  logic              rd,
    input  logic [ADDR_W-1:0] rd_add,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    // One extra bit so DEPTH itself is representable when it is a power of 2.
    localparam logic [ADDR_W:0] DEPTH_LIM = DEPTH[ADDR_W:0];

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_add;
    logic              wr_in_range;
    logic              rd_in_range;
    logic              wr_ok;
    logic              rd_ok;
    logic              collide;
    logic [DATA_W-1:0] rd_word;

    ram_clear_fsm #(
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_fsm (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_add (clr_add)
    );

    // Port qualification and the write-first read word. Addresses past the
    // end of a non-power-of-2 array read as zero and never alias a write.
    // On a collision the enabled bytes come from wr_data, the rest from the
    // array, which is exactly what the array holds after this edge.
    always_comb begin
        wr_in_range = ({1'b0, wr_add} < DEPTH_LIM);
        rd_in_range = ({1'b0, rd_add} < DEPTH_LIM);
        wr_ok       = wr && !busy && wr_in_range;
        rd_ok       = rd && !busy;
        collide     = wr_ok && (wr_add == rd_add);
        rd_word     = '0;
        if (rd_in_range) begin
            rd_word = mem[rd_add];
            if (collide) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (wr_be[i]) begin
                        rd_word[i*BYTE_W +: BYTE_W] = wr_data[i*BYTE_W +: BYTE_W];
                    end
                end
            end
        end
    end

    // Array write mux: the sweep owns the array while it runs (busy blocks
    // the user port then), and reset suppresses every write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we) begin
                mem[clr_add] <= '0;
            end else if (wr_ok) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (wr_be[i]) begin
                        mem[wr_add][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
                    end
                end
            end
        end
    end

    // Read pipeline. The data registers only load alongside a valid so that
    // rd_data holds between reads; reset flushes any read in flight.
    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              stage_valid;
            logic [DATA_W-1:0] stage_data;

            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_valid <= 1'b0;
                    stage_data  <= '0;
                    rd_valid    <= 1'b0;
                    rd_data     <= '0;
                end else begin
                    stage_valid <= rd_ok;
                    if (rd_ok) begin
                        stage_data <= rd_word;
                    end
                    rd_valid <= stage_valid;
                    if (stage_valid) begin
                        rd_data <= stage_data;
                    end
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_valid <= 1'b0;
                    rd_data  <= '0;
                end else begin
                    rd_valid <= rd_ok;
                    if (rd_ok) begin
                        rd_data <= rd_word;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_ram_dp_clr.sv
// tb_ram_dp_clr
//   Drives two ram_dp_clr instances from the same stimulus:
//     A: DATA_W=16, DEPTH=8, RD_LAT=1
//     B: DATA_W=16, DEPTH=6, RD_LAT=2 (addresses 6 and 7 are out of range)
//   Every accepted read pushes its expected word and due cycle into a
//   per-instance scoreboard queue; outputs are checked on each falling edge.
module tb_ram_dp_clr;

    localparam int DW      = 16;
    localparam int AW      = 3;
    localparam int DEPTH_A = 8;
    localparam int DEPTH_B = 6;
    localparam int LAT_A   = 1;
    localparam int LAT_B   = 2;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rd_item_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic          wr;
    logic [AW-1:0] wr_add;
    logic [DW-1:0] wr_data;
    logic [1:0]    wr_be;
    logic          rd;
    logic [AW-1:0] rd_add;

    logic          busy_a;
    logic          rd_valid_a;
    logic [DW-1:0] rd_data_a;
    logic          busy_b;
    logic          rd_valid_b;
    logic [DW-1:0] rd_data_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state, index 0 = instance A, 1 = instance B.
    logic [DW-1:0] mdl_mem [2][8];
    int            depth [2] = '{DEPTH_A, DEPTH_B};
    int            lat   [2] = '{LAT_A, LAT_B};
    bit            in_rst    [2];
    bit            sweeping  [2];
    int            sweep_cnt [2];
    logic [DW-1:0] last_data [2];
    bit            force_en  [2];
    logic [DW-1:0] force_val [2];
    rd_item_t      sb_a [$];
    rd_item_t      sb_b [$];

    always #5 clk = ~clk;

    ram_dp_clr #(
        .DATA_W(DW), .DEPTH(DEPTH_A), .RD_LAT(LAT_A), .CLEAR_ON_RESET(1)
    ) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_a),
        .wr(wr), .wr_add(wr_add), .wr_data(wr_data), .wr_be(wr_be),
        .rd(rd), .rd_add(rd_add), .rd_data(rd_data_a), .rd_valid(rd_valid_a)
    );

    ram_dp_clr #(
        .DATA_W(DW), .DEPTH(DEPTH_B), .RD_LAT(LAT_B), .CLEAR_ON_RESET(1)
    ) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_b),
        .wr(wr), .wr_add(wr_add), .wr_data(wr_data), .wr_be(wr_be),
        .rd(rd), .rd_add(rd_add), .rd_data(rd_data_b), .rd_valid(rd_valid_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)",
                     tag, observed, expected, cyc);
        end
    endtask

    function automatic bit mdl_busy(input int k);
        return in_rst[k] || sweeping[k];
    endfunction

    // Advance the model of instance k across one rising edge.
    task automatic model_edge(input int k);
        logic [DW-1:0] word;
        rd_item_t      item;
        if (rst) begin
            in_rst[k]    = 1'b1;
            sweeping[k]  = 1'b1;
            sweep_cnt[k] = 0;
            last_data[k] = '0;
            if (k == 0) sb_a.delete();
            else        sb_b.delete();
            return;
        end
        if (sweeping[k]) begin
            mdl_mem[k][sweep_cnt[k]] = '0;
            if (sweep_cnt[k] == depth[k] - 1) sweeping[k] = 1'b0;
            else                              sweep_cnt[k]++;
        end else if (!in_rst[k]) begin
            if (rd) begin
                word = '0;
                if (int'(rd_add) < depth[k]) begin
                    word = mdl_mem[k][rd_add];
                    if (wr && (wr_add == rd_add)) begin
                        for (int i = 0; i < 2; i++) begin
                            if (wr_be[i]) word[8*i +: 8] = wr_data[8*i +: 8];
                        end
                    end
                end
                item.due  = cyc + lat[k] - 1;
                item.data = force_en[k] ? force_val[k] : word;
                if (k == 0) sb_a.push_back(item);
                else        sb_b.push_back(item);
            end
            if (wr && (int'(wr_add) < depth[k])) begin
                for (int i = 0; i < 2; i++) begin
                    if (wr_be[i]) mdl_mem[k][wr_add][8*i +: 8] = wr_data[8*i +: 8];
                end
            end
            if (clr) begin
                sweeping[k]  = 1'b1;
                sweep_cnt[k] = 0;
            end
        end
        in_rst[k] = 1'b0;
    endtask

    // Compare instance k outputs against the scoreboard and model.
    task automatic check_instance(input int k);
        logic          v;
        logic          b;
        logic [DW-1:0] d;
        bit            exp_v;
        rd_item_t      item;
        string         s;
        exp_v = 1'b0;
        if (k == 0) begin
            s = "A"; v = rd_valid_a; d = rd_data_a; b = busy_a;
            if (sb_a.size() > 0 && sb_a[0].due == cyc) begin
                exp_v = 1'b1;
                item  = sb_a.pop_front();
            end
        end else begin
            s = "B"; v = rd_valid_b; d = rd_data_b; b = busy_b;
            if (sb_b.size() > 0 && sb_b[0].due == cyc) begin
                exp_v = 1'b1;
                item  = sb_b.pop_front();
            end
        end
        checkOutput({"rd_valid_", s}, 32'(v), 32'(exp_v));
        if (exp_v) begin
            checkOutput({"rd_data_", s}, 32'(d), 32'(item.data));
            last_data[k] = item.data;
        end else begin
            checkOutput({"rd_hold_", s}, 32'(d), 32'(last_data[k]));
        end
        checkOutput({"busy_", s}, 32'(b), 32'(mdl_busy(k)));
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge(0);
        model_edge(1);
        force_en[0] = 1'b0;
        force_en[1] = 1'b0;
        @(negedge clk);
        check_instance(0);
        check_instance(1);
    endtask

    task automatic applyStimulus(input logic r, input logic c, input logic w,
                                 input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                 input logic [1:0] be, input logic rr,
                                 input logic [AW-1:0] ra);
        rst = r; clr = c; wr = w; wr_add = wa; wr_data = wd; wr_be = be;
        rd = rr; rd_add = ra;
        tick();
    endtask

    task automatic idle_cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0, '0);
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [1:0] be);
        applyStimulus(1'b0, 1'b0, 1'b1, a, d, be, 1'b0, '0);
    endtask

    task automatic read_word(input logic [AW-1:0] a, input logic [DW-1:0] exp_a,
                             input logic [DW-1:0] exp_b);
        force_en[0] = 1'b1; force_val[0] = exp_a;
        force_en[1] = 1'b1; force_val[1] = exp_b;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 2'b00, 1'b1, a);
    endtask

    task automatic collide(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [1:0] be, input logic [DW-1:0] expected);
        force_en[0] = 1'b1; force_val[0] = expected;
        force_en[1] = 1'b1; force_val[1] = expected;
        applyStimulus(1'b0, 1'b0, 1'b1, a, d, be, 1'b1, a);
    endtask

    // Pulse reset and count the falling edges on which each busy is high.
    task automatic reset_and_measure(input string tag);
        int len_a;
        int len_b;
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0, '0);
        len_a = int'(busy_a);
        len_b = int'(busy_b);
        for (int i = 0; i < 14; i++) begin
            idle_cycle();
            len_a += int'(busy_a);
            len_b += int'(busy_b);
        end
        checkOutput({tag, "_busy_len_A"}, 32'(len_a), 32'(DEPTH_A));
        checkOutput({tag, "_busy_len_B"}, 32'(len_b), 32'(DEPTH_B));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && (busy_a || busy_b); i++) idle_cycle();
        checkOutput("wait_idle", 32'(busy_a | busy_b), 32'(0));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int            la;
        int            lb;
        logic [AW-1:0] ra;
        logic [AW-1:0] wa;
        rst = 1'b1; clr = 1'b0; wr = 1'b0; rd = 1'b0;
        wr_add = '0; rd_add = '0; wr_data = '0; wr_be = 2'b00;
        $display("[TB] starting ram_dp_clr bench");

        // Reset sweep length, then every address reads zero.
        reset_and_measure("reset");
        for (int a = 0; a < 8; a++) read_word(AW'(a), 16'h0000, 16'h0000);
        idle_cycle();
        idle_cycle();

        // Byte enables.
        write_word(3'd3, 16'hBEEF, 2'b11);
        write_word(3'd3, 16'h1234, 2'b10);
        read_word(3'd3, 16'h12EF, 16'h12EF);
        idle_cycle();
        idle_cycle();

        // Write-first collisions, full, empty and partial byte enables.
        write_word(3'd5, 16'h0011, 2'b11);
        collide(3'd5, 16'h00A5, 2'b11, 16'h00A5);
        write_word(3'd5, 16'h0011, 2'b11);
        collide(3'd5, 16'h00A5, 2'b00, 16'h0011);
        collide(3'd5, 16'hBBCC, 2'b01, 16'h00CC);
        read_word(3'd5, 16'h00CC, 16'h00CC);
        idle_cycle();
        idle_cycle();

        // Back-to-back reads.
        for (int a = 0; a < 4; a++) write_word(AW'(a), DW'(10 + a), 2'b11);
        for (int a = 0; a < 4; a++) read_word(AW'(a), DW'(10 + a), DW'(10 + a));
        idle_cycle();
        idle_cycle();
        idle_cycle();

        // clr with a same-cycle read; writes and clr ignored while busy.
        write_word(3'd2, 16'h007E, 2'b11);
        force_en[0] = 1'b1; force_val[0] = 16'h007E;
        force_en[1] = 1'b1; force_val[1] = 16'h007E;
        applyStimulus(1'b0, 1'b1, 1'b0, '0, '0, 2'b00, 1'b1, 3'd2);
        la = int'(busy_a);
        lb = int'(busy_b);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 3'd2, 16'h5555, 2'b11, 1'b0, '0);
            la += int'(busy_a);
            lb += int'(busy_b);
        end
        for (int i = 0; i < 6; i++) begin
            idle_cycle();
            la += int'(busy_a);
            lb += int'(busy_b);
        end
        checkOutput("clr_busy_len_A", 32'(la), 32'(DEPTH_A));
        checkOutput("clr_busy_len_B", 32'(lb), 32'(DEPTH_B));
        wait_idle();
        read_word(3'd2, 16'h0000, 16'h0000);
        idle_cycle();
        idle_cycle();

        // Reset with a read in flight, then reset in the middle of a sweep.
        write_word(3'd1, 16'h4242, 2'b11);
        read_word(3'd1, 16'h4242, 16'h4242);
        reset_and_measure("rst_read");
        idle_cycle();
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0, '0);
        idle_cycle();
        idle_cycle();
        idle_cycle();
        reset_and_measure("rst_sweep");
        wait_idle();

        // Out-of-range addresses on the 6-word instance.
        write_word(3'd7, 16'h7777, 2'b11);
        write_word(3'd6, 16'h6666, 2'b11);
        read_word(3'd7, 16'h7777, 16'h0000);
        read_word(3'd6, 16'h6666, 16'h0000);
        idle_cycle();
        idle_cycle();

        // Random traffic against the model, collisions made likely.
        for (int i = 0; i < 300; i++) begin
            wa = AW'($urandom_range(0, 7));
            ra = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 7));
            applyStimulus(1'b0, 1'($urandom_range(0, 39) == 0),
                          1'($urandom_range(0, 1)), wa, DW'($urandom),
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ra);
        end
        for (int i = 0; i < 4; i++) idle_cycle();
        checkOutput("drain_A", 32'(sb_a.size()), 32'(0));
        checkOutput("drain_B", 32'(sb_b.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
